// File: rtl/uart_rx_sipo_if.sv
// Receive-side UART bundle: serial line and parity config in, byte and status out.
interface uart_rx_sipo_if;
  logic       data_rx;
  logic [1:0] parity_type;
  logic [7:0] data_out;
  logic       done_flag;
  logic       active_flag;
  logic       parity_error;
  logic       stop_error;

  modport master (
    output data_rx, parity_type,
    input  data_out, done_flag, active_flag, parity_error, stop_error
  );

  modport slave (
    input  data_rx, parity_type,
    output data_out, done_flag, active_flag, parity_error, stop_error
  );
endinterface

// File: rtl/uart_rx_sipo.sv
// UART receiver: oversampled start detect, mid-bit sampling, LSB-first byte
// reassembly, optional parity and stop-bit checking with a one-cycle done strobe.
module uart_rx_sipo #(
  parameter int OVERSAMPLE = 16
) (
  input  logic          baud_clk,
  input  logic          reset_n,
  uart_rx_sipo_if.slave bus
);
  localparam int            CW      = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4
  } state_t;

  state_t        r_state, w_next;
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift, r_data;
  logic [1:0]    r_ptype;
  logic          r_par, r_done, r_active, r_perr, r_serr;

  logic w_rx_s, w_half, w_last, w_has_par, w_xor, w_par_err;
  logic w_accept, w_false, w_go_data, w_shift, w_par_ld, w_finish, w_cnt_clr;

  assign w_rx_s    = r_sync[1];
  assign w_half    = (r_cnt == HALF_M1);
  assign w_last    = (r_cnt == LAST);
  assign w_has_par = (r_ptype == 2'b01) || (r_ptype == 2'b10);
  assign w_xor     = ^{r_shift, r_par};
  assign w_par_err = (r_ptype == 2'b10) ? w_xor :
                     (r_ptype == 2'b01) ? ~w_xor : 1'b0;

  always_ff @(posedge baud_clk or negedge reset_n)
    if (!reset_n) r_sync <= 2'b11;
    else          r_sync <= {r_sync[0], bus.data_rx};

  always_ff @(posedge baud_clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!w_rx_s) w_next = START;
      START:   if (w_half)  w_next = w_rx_s ? IDLE : DATA;
      DATA:    if (w_last && r_idx == 3'd7) w_next = w_has_par ? PARITY : STOP;
      PARITY:  if (w_last)  w_next = STOP;
      STOP:    if (w_last)  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_accept  = 1'b0;
    w_false   = 1'b0;
    w_go_data = 1'b0;
    w_shift   = 1'b0;
    w_par_ld  = 1'b0;
    w_finish  = 1'b0;
    case (r_state)
      IDLE:   w_accept  = !w_rx_s;
      START: begin
        w_false   = w_half &  w_rx_s;
        w_go_data = w_half & !w_rx_s;
      end
      DATA:   w_shift   = w_last;
      PARITY: w_par_ld  = w_last;
      STOP:   w_finish  = w_last;
      default: ;
    endcase
    // Counter restarts on every state change and after each bit sample so
    // non-power-of-two oversample ratios still wrap at the bit boundary.
    w_cnt_clr = (r_state == IDLE) || (w_next != r_state) || w_last;
  end

  always_ff @(posedge baud_clk or negedge reset_n)
    if (!reset_n) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_ptype  <= '0;
      r_par    <= 1'b0;
      r_data   <= '0;
      r_done   <= 1'b0;
      r_active <= 1'b0;
      r_perr   <= 1'b0;
      r_serr   <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_clr ? '0 : r_cnt + 1'b1;
      r_done <= w_finish;
      if (w_accept) begin
        r_ptype  <= bus.parity_type;
        r_active <= 1'b1;
      end
      if (w_false || w_finish) r_active <= 1'b0;
      if (w_go_data) r_idx <= '0;
      if (w_shift) begin
        r_shift <= {w_rx_s, r_shift[7:1]};
        r_idx   <= r_idx + 1'b1;
      end
      if (w_par_ld) r_par <= w_rx_s;
      if (w_finish) begin
        r_data <= r_shift;
        r_serr <= ~w_rx_s;
        r_perr <= w_par_err;
      end
    end

  assign bus.data_out     = r_data;
  assign bus.done_flag    = r_done;
  assign bus.active_flag  = r_active;
  assign bus.parity_error = r_perr;
  assign bus.stop_error   = r_serr;
endmodule

// File: tb/tb_uart_rx_sipo.sv
// Bench for uart_rx_sipo: directed frame table, corner-case sequences and
// random frames scored against a frame-level reference model.
module tb_uart_rx_sipo;
  localparam int OS = 16;

  logic baud_clk, reset_n;
  int   cyc = 0;
  int   checks = 0, errors = 0;

  uart_rx_sipo_if bus ();

  uart_rx_sipo #(.OVERSAMPLE(OS)) dut (
    .baud_clk (baud_clk),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  initial begin
    baud_clk = 1'b0;
    forever #5 baud_clk = ~baud_clk;
  end

  always @(posedge baud_clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       se;
    int         t;
  } rec_t;

  typedef struct {
    logic [7:0] d;
    logic [1:0] pt;
    logic [1:0] pt_mid;
    logic       pb;
    logic       sb;
    logic [7:0] ed;
    logic       epe;
    logic       ese;
  } vec_t;

  rec_t q[$];

  always @(negedge baud_clk)
    if (bus.done_flag === 1'b1)
      q.push_back('{bus.data_out, bus.parity_error, bus.stop_error, cyc});

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic has_par(input logic [1:0] pt);
    return (pt == 2'b01) || (pt == 2'b10);
  endfunction

  // Frame-level reference: what the receiver must report for a given frame.
  function automatic rec_t model(input logic [7:0] d, input logic [1:0] pt,
                                 input logic pb, input logic sb, input int t0);
    rec_t r;
    int   ones;
    ones = $countones(d) + int'(pb);
    r.d  = d;
    r.se = !sb;
    if (pt == 2'b10)      r.pe = (ones % 2) != 0;
    else if (pt == 2'b01) r.pe = (ones % 2) == 0;
    else                  r.pe = 1'b0;
    r.t = t0 + 3 + OS/2 + 9*OS + (has_par(pt) ? OS : 0);
    return r;
  endfunction

  task automatic ticks(input int n);
    repeat (n) @(negedge baud_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic [1:0] pt_mid,
                            input logic pb, input logic sb, output int t0);
    bus.parity_type = pt;
    bus.data_rx = 1'b0;
    t0 = cyc;
    ticks(OS);
    bus.parity_type = pt_mid;
    for (int i = 0; i < 8; i++) begin
      bus.data_rx = d[i];
      ticks(OS);
    end
    if (has_par(pt)) begin
      bus.data_rx = pb;
      ticks(OS);
    end
    bus.data_rx = sb;
    ticks(OS);
    bus.data_rx = 1'b1;
  endtask

  task automatic expect_frame(input string nm, input rec_t e);
    rec_t r;
    if (q.size() == 0) begin
      check({nm, ".present"}, 0, 1);
      return;
    end
    r = q.pop_front();
    check({nm, ".data"}, r.d, e.d);
    check({nm, ".perr"}, r.pe, e.pe);
    check({nm, ".serr"}, r.se, e.se);
    check({nm, ".when"}, r.t, e.t);
  endtask

  vec_t tbl[10];

  initial begin
    int   t0, t1;
    rec_t e;
    logic [7:0] rd;
    logic [1:0] rpt;
    logic       rpb, rsb;

    tbl[0] = '{8'hA5, 2'b00, 2'b00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h3C, 2'b10, 2'b10, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    tbl[2] = '{8'h3C, 2'b10, 2'b10, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    tbl[3] = '{8'h01, 2'b01, 2'b01, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[4] = '{8'h01, 2'b01, 2'b01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[5] = '{8'h55, 2'b00, 2'b00, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1};
    tbl[6] = '{8'h0F, 2'b00, 2'b00, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0};
    tbl[7] = '{8'h80, 2'b11, 2'b11, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
    tbl[8] = '{8'h3C, 2'b10, 2'b00, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    tbl[9] = '{8'hFF, 2'b10, 2'b10, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1};

    bus.data_rx     = 1'b1;
    bus.parity_type = 2'b00;
    reset_n         = 1'b0;
    ticks(3);
    check("reset.data_out", bus.data_out, 8'h00);
    check("reset.done",     bus.done_flag, 1'b0);
    check("reset.active",   bus.active_flag, 1'b0);
    check("reset.perr",     bus.parity_error, 1'b0);
    check("reset.serr",     bus.stop_error, 1'b0);
    reset_n = 1'b1;
    ticks(4);

    // Directed frame table
    for (int i = 0; i < 10; i++) begin
      q.delete();
      send_frame(tbl[i].d, tbl[i].pt, tbl[i].pt_mid, tbl[i].pb, tbl[i].sb, t0);
      ticks(2*OS);
      check($sformatf("tbl%0d.count", i), q.size(), 1);
      e = '{tbl[i].ed, tbl[i].epe, tbl[i].ese, t0 + 3 + OS/2 + 9*OS + (has_par(tbl[i].pt) ? OS : 0)};
      expect_frame($sformatf("tbl%0d", i), e);
      check($sformatf("tbl%0d.held_data", i), bus.data_out, tbl[i].ed);
      check($sformatf("tbl%0d.held_serr", i), bus.stop_error, tbl[i].ese);
    end

    // False start: line low for 4 ticks only
    q.delete();
    rd = bus.data_out;
    bus.data_rx = 1'b0;
    t0 = cyc;
    ticks(4);
    bus.data_rx = 1'b1;
    ticks(t0 + 3 - cyc);
    check("false.active_pre", bus.active_flag, 1'b1);
    ticks(t0 + 10 - cyc);
    check("false.active_hold", bus.active_flag, 1'b1);
    ticks(1);
    check("false.active_fall", bus.active_flag, 1'b0);
    ticks(2*OS);
    check("false.no_done", q.size(), 0);
    check("false.data_kept", bus.data_out, rd);

    // Back-to-back frames, no idle between stop and next start
    q.delete();
    send_frame(8'h12, 2'b00, 2'b00, 1'b0, 1'b1, t0);
    send_frame(8'h34, 2'b00, 2'b00, 1'b0, 1'b1, t1);
    ticks(2*OS);
    check("b2b.count", q.size(), 2);
    expect_frame("b2b.first",  model(8'h12, 2'b00, 1'b0, 1'b1, t0));
    expect_frame("b2b.second", model(8'h34, 2'b00, 1'b0, 1'b1, t1));

    // Reset asserted during D4
    q.delete();
    bus.parity_type = 2'b00;
    rd = 8'h77;
    bus.data_rx = 1'b0;
    ticks(OS);
    for (int i = 0; i < 4; i++) begin
      bus.data_rx = rd[i];
      ticks(OS);
    end
    bus.data_rx = rd[4];
    ticks(OS/2);
    check("rst.active_before", bus.active_flag, 1'b1);
    reset_n = 1'b0;
    #1;
    check("rst.data_out", bus.data_out, 8'h00);
    check("rst.active",   bus.active_flag, 1'b0);
    check("rst.done",     bus.done_flag, 1'b0);
    check("rst.perr",     bus.parity_error, 1'b0);
    check("rst.serr",     bus.stop_error, 1'b0);
    bus.data_rx = 1'b1;
    ticks(3);
    reset_n = 1'b1;
    ticks(2*OS);
    check("rst.no_done", q.size(), 0);
    check("rst.idle",    bus.active_flag, 1'b0);
    send_frame(8'h99, 2'b00, 2'b00, 1'b0, 1'b1, t0);
    ticks(2*OS);
    check("rst.next_count", q.size(), 1);
    expect_frame("rst.next", model(8'h99, 2'b00, 1'b0, 1'b1, t0));

    // Random frames against the reference model
    for (int i = 0; i < 30; i++) begin
      q.delete();
      rd  = 8'($urandom_range(0, 255));
      rpt = 2'($urandom_range(0, 3));
      rpb = 1'($urandom_range(0, 1));
      rsb = ($urandom_range(0, 3) != 0);
      send_frame(rd, rpt, 2'($urandom_range(0, 3)), rpb, rsb, t0);
      ticks(2*OS);
      check($sformatf("rnd%0d.count", i), q.size(), 1);
      expect_frame($sformatf("rnd%0d", i), model(rd, rpt, rpb, rsb, t0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
